// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch (f), memory-stage (d)
// and writeback (w) requesters; one transaction outstanding, response timeout flagged sticky.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_f_valid,
  input  logic [ADDR_W-1:0] i_f_addr,
  input  logic [CMD_W-1:0]  i_f_cmd,
  input  logic [DATA_W-1:0] i_f_data,
  output logic              o_f_ready,
  output logic              o_f_res_valid,
  output logic [DATA_W-1:0] o_f_data,
  input  logic              i_f_res_ready,

  input  logic              i_d_valid,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [CMD_W-1:0]  i_d_cmd,
  input  logic [DATA_W-1:0] i_d_data,
  output logic              o_d_ready,
  output logic              o_d_res_valid,
  output logic [DATA_W-1:0] o_d_data,
  input  logic              i_d_res_ready,

  input  logic              i_w_valid,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [CMD_W-1:0]  i_w_cmd,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              o_w_ready,
  output logic              o_w_res_valid,
  output logic [DATA_W-1:0] o_w_data,
  input  logic              i_w_res_ready,

  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [CMD_W-1:0]  o_mem_cmd,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_ready,
  input  logic              i_mem_res_valid,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_mem_res_ready,

  output logic              o_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DELIVER} state_t;
  typedef enum logic [1:0] {OWN_F, OWN_D, OWN_W} owner_t;

  state_t            r_state;
  state_t            w_next_state;
  owner_t            r_owner;
  owner_t            r_rr_ptr;
  owner_t            w_grant;
  logic              w_grant_any;
  logic              w_accept;
  logic              w_owner_res_ready;
  logic              w_deliver;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [CMD_W-1:0]  w_sel_cmd;
  logic [DATA_W-1:0] w_sel_data;
  logic [ADDR_W-1:0] r_addr;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  // Search order starts with the requester after the last one served.
  always_comb begin
    w_grant_any = i_f_valid | i_d_valid | i_w_valid;
    w_grant     = OWN_F;
    case (r_rr_ptr)
      OWN_F: begin
        if (i_d_valid)      w_grant = OWN_D;
        else if (i_w_valid) w_grant = OWN_W;
        else                w_grant = OWN_F;
      end
      OWN_D: begin
        if (i_w_valid)      w_grant = OWN_W;
        else if (i_f_valid) w_grant = OWN_F;
        else                w_grant = OWN_D;
      end
      default: begin
        if (i_f_valid)      w_grant = OWN_F;
        else if (i_d_valid) w_grant = OWN_D;
        else                w_grant = OWN_W;
      end
    endcase
  end

  always_comb begin
    w_sel_addr = i_f_addr;
    w_sel_cmd  = i_f_cmd;
    w_sel_data = i_f_data;
    case (w_grant)
      OWN_D: begin
        w_sel_addr = i_d_addr;
        w_sel_cmd  = i_d_cmd;
        w_sel_data = i_d_data;
      end
      OWN_W: begin
        w_sel_addr = i_w_addr;
        w_sel_cmd  = i_w_cmd;
        w_sel_data = i_w_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_owner)
      OWN_F:   w_owner_res_ready = i_f_res_ready;
      OWN_D:   w_owner_res_ready = i_d_res_ready;
      default: w_owner_res_ready = i_w_res_ready;
    endcase
  end

  assign w_accept = reset && (r_state == S_IDLE) && w_grant_any;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_grant_any) w_next_state = S_REQ;
      S_REQ:     if (i_mem_ready) w_next_state = S_RESP;
      S_RESP:    if (i_mem_res_valid || (r_cnt == CNT_LAST)) w_next_state = S_DELIVER;
      S_DELIVER: if (w_owner_res_ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner  <= OWN_W;
      r_rr_ptr <= OWN_W;
      r_addr   <= '0;
      r_cmd    <= '0;
      r_wdata  <= '0;
      r_resp   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_owner <= w_grant;
            r_addr  <= w_sel_addr;
            r_cmd   <= w_sel_cmd;
            r_wdata <= w_sel_data;
          end
        end
        S_REQ: begin
          if (i_mem_ready) r_cnt <= '0;
        end
        S_RESP: begin
          if (i_mem_res_valid) begin
            r_resp <= i_mem_data;
          end else if (r_cnt == CNT_LAST) begin
            r_resp <= '0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (w_owner_res_ready) r_rr_ptr <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign w_deliver = (r_state == S_DELIVER);

  assign o_f_ready = w_accept && (w_grant == OWN_F);
  assign o_d_ready = w_accept && (w_grant == OWN_D);
  assign o_w_ready = w_accept && (w_grant == OWN_W);

  assign o_f_res_valid = w_deliver && (r_owner == OWN_F);
  assign o_d_res_valid = w_deliver && (r_owner == OWN_D);
  assign o_w_res_valid = w_deliver && (r_owner == OWN_W);

  assign o_f_data = o_f_res_valid ? r_resp : '0;
  assign o_d_data = o_d_res_valid ? r_resp : '0;
  assign o_w_data = o_w_res_valid ? r_resp : '0;

  assign o_mem_valid     = (r_state == S_REQ);
  assign o_mem_addr      = r_addr;
  assign o_mem_cmd       = r_cmd;
  assign o_mem_data      = r_wdata;
  assign o_mem_res_ready = (r_state == S_RESP);
  assign o_err           = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 16;
  localparam logic [CW-1:0] CMD_RD = 2'b01;
  localparam logic [CW-1:0] CMD_WR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [2:0]         v;
  logic [2:0][AW-1:0] a;
  logic [2:0][CW-1:0] c;
  logic [2:0][DW-1:0] wd;
  logic [2:0]         rr;
  logic [2:0]         rdy;
  logic [2:0]         resv;
  logic [2:0][DW-1:0] rdat;
  logic               mem_valid, mem_ready, mem_res_valid, mem_res_ready, err;
  logic [AW-1:0]      mem_addr;
  logic [CW-1:0]      mem_cmd;
  logic [DW-1:0]      mem_wdata, mem_data;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_f_valid(v[0]), .i_f_addr(a[0]), .i_f_cmd(c[0]), .i_f_data(wd[0]),
    .o_f_ready(rdy[0]), .o_f_res_valid(resv[0]), .o_f_data(rdat[0]), .i_f_res_ready(rr[0]),
    .i_d_valid(v[1]), .i_d_addr(a[1]), .i_d_cmd(c[1]), .i_d_data(wd[1]),
    .o_d_ready(rdy[1]), .o_d_res_valid(resv[1]), .o_d_data(rdat[1]), .i_d_res_ready(rr[1]),
    .i_w_valid(v[2]), .i_w_addr(a[2]), .i_w_cmd(c[2]), .i_w_data(wd[2]),
    .o_w_ready(rdy[2]), .o_w_res_valid(resv[2]), .o_w_data(rdat[2]), .i_w_res_ready(rr[2]),
    .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_cmd(mem_cmd), .o_mem_data(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_res_valid(mem_res_valid), .i_mem_data(mem_data),
    .o_mem_res_ready(mem_res_ready), .o_err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory (-1 = nobody), whether the request went out,
  // whether a response (or timeout) is in hand, and who was served last.
  int                 m_who, m_last, m_wait, g;
  bit                 m_sent, m_done, m_err;
  logic [AW-1:0]      m_addr;
  logic [CW-1:0]      m_cmd;
  logic [DW-1:0]      m_wd, m_resp;
  logic [2:0]         e_rdy, e_resv;
  logic [2:0][DW-1:0] e_dat;
  int                 q_grant[$];

  always @(negedge clk) begin
    if (!reset) begin
      m_who = -1; m_last = 2; m_wait = 0; m_sent = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_cmd = '0; m_wd = '0; m_resp = '0;
    end
    g = -1;
    if (reset && m_who < 0)
      for (int k = 1; k <= 3; k++)
        if (g < 0 && v[(m_last + k) % 3]) g = (m_last + k) % 3;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_resv = '0;
    e_dat  = '0;
    if (m_who >= 0 && m_done) begin
      e_resv[m_who] = 1'b1;
      e_dat[m_who]  = m_resp;
    end
    chk("ready", rdy, e_rdy);
    chk("res_valid", resv, e_resv);
    for (int r = 0; r < 3; r++) chk("res_data", rdat[r], e_dat[r]);
    chk("mem_valid", mem_valid, m_who >= 0 && !m_sent);
    chk("mem_res_ready", mem_res_ready, m_who >= 0 && m_sent && !m_done);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_cmd", mem_cmd, m_cmd);
    chk("mem_data", mem_wdata, m_wd);
    chk("err", err, m_err);
    for (int r = 0; r < 3; r++) if (rdy[r] === 1'b1) q_grant.push_back(r);
    if (reset) begin
      if (g >= 0) begin
        m_who = g; m_addr = a[g]; m_cmd = c[g]; m_wd = wd[g]; m_sent = 0; m_done = 0;
      end else if (m_who >= 0) begin
        if (!m_sent) begin
          if (mem_ready) begin m_sent = 1; m_wait = 0; end
        end else if (!m_done) begin
          if (mem_res_valid) begin m_resp = mem_data; m_done = 1; end
          else if (m_wait == TO - 1) begin m_resp = '0; m_err = 1; m_done = 1; end
          else m_wait++;
        end else if (rr[m_who]) begin
          m_last = m_who; m_who = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One complete transaction for requester r, assumed to win arbitration from IDLE.
  task automatic run_txn(input int r, input logic [AW-1:0] ad, input logic [CW-1:0] cm,
                         input logic [DW-1:0] wdat, input int stall, input int rdly,
                         input logic [DW-1:0] rdata, input bit respond, input int hold,
                         input int raise_r);
    logic [2:0]    one;
    logic [DW-1:0] expd;
    one = 3'b001 << r;
    v[r] = 1'b1; a[r] = ad; c[r] = cm; wd[r] = wdat;
    settle();
    chk("accept_pulse", rdy, one);
    tick();
    v[r] = 1'b0;
    if (raise_r >= 0) v[raise_r] = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      settle();
      chk("stall_mem_valid", mem_valid, 1);
      chk("stall_mem_addr", mem_addr, ad);
      chk("stall_mem_data", mem_wdata, wdat);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("req_mem_valid", mem_valid, 1);
    chk("req_mem_cmd", mem_cmd, cm);
    tick();
    mem_ready = 1'b0;
    if (respond) begin
      repeat (rdly) tick();
      mem_res_valid = 1'b1; mem_data = rdata;
      tick();
      mem_res_valid = 1'b0;
      expd = rdata;
    end else begin
      repeat (TO) tick();
      expd = '0;
    end
    rr[r] = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      settle();
      chk("hold_res_valid", resv, one);
      chk("hold_res_data", rdat[r], expd);
      chk("hold_no_ready", rdy, 3'b000);
      tick();
    end
    rr[r] = 1'b1;
    settle();
    chk("deliver_valid", resv, one);
    chk("deliver_data", rdat[r], expd);
    tick();
    settle();
    chk("idle_res_valid", resv, 3'b000);
  endtask

  int exp_order[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    reset = 1'b0; v = '0; a = '0; c = '0; wd = '0; rr = '1;
    mem_ready = 1'b0; mem_res_valid = 1'b0; mem_data = '0;
    repeat (3) tick();
    settle();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    tick();

    // f read, immediate memory accept, data two cycles after accept
    run_txn(0, 32'h100, CMD_RD, '0, 0, 0, 32'hDEADBEEF, 1, 0, -1);
    // d read with consumer stalled 5 cycles while f waits
    run_txn(1, 32'h200, CMD_RD, '0, 0, 0, 32'h12345678, 1, 5, 0);
    settle();
    chk("t3_f_after_consume", rdy, 3'b001);
    run_txn(0, 32'h300, CMD_RD, '0, 0, 1, 32'h0000A5A5, 1, 0, -1);
    // w write with memory stalling 3 cycles
    run_txn(2, 32'h40, CMD_WR, 32'h0000CAFE, 3, 0, 32'h1, 1, 0, -1);

    // all three requesting from reset: strict rotation
    reset = 1'b0;
    v = 3'b111;
    a[0] = 32'h10; a[1] = 32'h20; a[2] = 32'h30;
    c[0] = CMD_RD; c[1] = CMD_RD; c[2] = CMD_WR;
    mem_ready = 1'b1; mem_res_valid = 1'b1; mem_data = 32'h77;
    repeat (2) tick();
    q_grant.delete();
    reset = 1'b1;
    for (int i = 0; i < 80 && q_grant.size() < 6; i++) tick();
    v = '0;
    repeat (6) tick();
    mem_ready = 1'b0; mem_res_valid = 1'b0;
    tick();
    chk("t2_grant_count", q_grant.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      if (i < q_grant.size()) chk("t2_grant_order", q_grant[i], exp_order[i]);

    // timeout on f, then a good d transaction with err staying set
    run_txn(0, 32'h500, CMD_RD, '0, 0, 0, '0, 0, 0, -1);
    settle();
    chk("t5_err_set", err, 1);
    run_txn(1, 32'h600, CMD_RD, '0, 0, 0, 32'h0000BEEF, 1, 0, -1);
    settle();
    chk("t5_err_sticky", err, 1);

    // reset while waiting for the response
    v[0] = 1'b1; a[0] = 32'h700; c[0] = CMD_RD;
    settle();
    chk("t6_grant_f", rdy, 3'b001);
    tick();
    v[0] = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    settle();
    chk("t6_rst_res_ready", mem_res_ready, 0);
    chk("t6_rst_mem_valid", mem_valid, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_res_valid", resv, 3'b000);
    tick();
    reset = 1'b1; mem_res_valid = 1'b1; mem_data = 32'h999;
    settle();
    chk("t6_late_res_ready", mem_res_ready, 0);
    tick();
    mem_res_valid = 1'b0;
    settle();
    chk("t6_late_no_res", resv, 3'b000);
    v[1] = 1'b1; a[1] = 32'h800; c[1] = CMD_RD;
    run_txn(0, 32'h900, CMD_RD, '0, 0, 0, 32'h00001111, 1, 0, -1);
    run_txn(1, 32'h800, CMD_RD, '0, 0, 2, 32'h00002222, 1, 1, -1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
